apb_host_sequencer: RTL and testbench

APB requester that drives the k-means RegFile's APB slave port from a simple command stream, replacing hand-timed bus stimulus with a synthesizable host-side engine. It accepts one command at a time (WRITE, READ, WAIT_IRQ) and runs a compliant setup/access transfer or waits on the core's `interupt` line. Each command returns exactly one response carrying read data and an error flag. It sits between a host/loader (or testbench) and `RegFile`, on the same clock.

---
 rtl/apb_host_pkg.sv | 41 ++++
 rtl/apb_timeout_cnt.sv | 38 +++
 rtl/apb_host_sequencer.sv | 159 +++++++++++++++
 tb/tb_apb_host_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_host_pkg.sv
// Shared types for the APB host sequencer: command opcodes, FSM states and the
// k-means RegFile register map.
package apb_host_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE    = 2'd0,
    CMD_READ     = 2'd1,
    CMD_WAIT_IRQ = 2'd2
  } cmd_op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_ACCESS   = 3'd2,
    S_WAIT_IRQ = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    internal_status = 4'd0,
    go              = 4'd1,
    cent_1          = 4'd2,
    cent_2          = 4'd3,
    cent_3          = 4'd4,
    cent_4          = 4'd5,
    cent_5          = 4'd6,
    cent_6          = 4'd7,
    cent_7          = 4'd8,
    cent_8          = 4'd9,
    ram_addr        = 4'd10,
    ram_data        = 4'd11,
    first_ram_addr  = 4'd12,
    last_ram_addr   = 4'd13
  } regfile_addr_t;

  // WRITE and READ are the only opcodes that produce an APB transfer.
  function automatic logic is_xfer_op(input logic [1:0] op);
    return (op == CMD_WRITE) || (op == CMD_READ);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating cycle counter that flags the last permitted cycle of a wait.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count value k means this is the (k+1)-th waiting cycle.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/apb_host_sequencer.sv
// APB requester: turns a WRITE/READ/WAIT_IRQ command stream into APB transfers
// or interrupt waits against the k-means RegFile, one response per command.
module apb_host_sequencer
  import apb_host_pkg::*;
#(
  parameter int unsigned addrWidth      = 9,
  parameter int unsigned dataWidth      = 91,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_data,
  output logic                 rsp_err,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready,
  input  logic                 interupt,
  output logic                 busy
);

  state_t                 state_q, state_d;
  logic [addrWidth-1:0]   paddr_q, paddr_d;
  logic [dataWidth-1:0]   pwdata_q, pwdata_d;
  logic [dataWidth-1:0]   rsp_data_q, rsp_data_d;
  logic                   pwrite_q, pwrite_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   psel_q, penable_q, rsp_valid_q, busy_q;
  logic                   irq_seen_q, irq_clr;
  logic                   tmo_active, tmo_expired;

  assign tmo_active = (state_q == S_ACCESS) || (state_q == S_WAIT_IRQ);

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (!tmo_active),
    .enable (tmo_active),
    .expired(tmo_expired)
  );

  assign cmd_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    irq_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (is_xfer_op(cmd_op)) begin
            paddr_d  = cmd_addr;
            pwdata_d = cmd_data;
            pwrite_d = (cmd_op == CMD_WRITE);
            state_d  = S_SETUP;
          end else if (cmd_op == CMD_WAIT_IRQ) begin
            state_d = S_WAIT_IRQ;
          end else begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end
        end
      end

      S_SETUP: state_d = S_ACCESS;

      S_ACCESS: begin
        // A ready slave wins over a timeout landing on the same cycle.
        if (pready) begin
          if (!pwrite_q) begin
            rsp_data_d = prdata;
          end
          state_d = S_RESP;
        end else if (tmo_expired) begin
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end

      S_WAIT_IRQ: begin
        if (irq_seen_q || interupt) begin
          irq_clr = 1'b1;
          state_d = S_RESP;
        end else if (tmo_expired) begin
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Bus and response flags are decoded from the next state so they leave a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      irq_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= (state_d == S_SETUP) || (state_d == S_ACCESS);
      penable_q   <= (state_d == S_ACCESS);
      rsp_valid_q <= (state_d == S_RESP);
      busy_q      <= (state_d != S_IDLE);
      // An interrupt coinciding with the clear must not be lost.
      irq_seen_q  <= interupt | (irq_seen_q & ~irq_clr);
    end
  end

  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_apb_host_sequencer.sv
// Bench for apb_host_sequencer: directed scenarios plus random commands checked
// against a command-level model of latency, response and interrupt bookkeeping.
module tb_apb_host_sequencer;
  import apb_host_pkg::*;

  localparam int AW  = 9;
  localparam int DW  = 91;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready, interupt, busy;
  logic [DW-1:0] pwdata, prdata;

  int checks = 0;
  int errors = 0;

  // Model of what the requester must remember between commands.
  logic          model_irq;
  logic [AW-1:0] model_paddr;
  logic [DW-1:0] model_pwdata;
  logic          model_pwrite;

  always #5 clk = ~clk;

  apb_host_sequencer #(
    .addrWidth(AW), .dataWidth(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .interupt(interupt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Issues one command at a negedge while idle. nwait: pready-low ACCESS cycles
  // before ready; irq_cyc: cycle after accept to pulse interupt (-1 none);
  // hold: response cycles with rsp_ready low.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input int nwait, input logic [DW-1:0] rdata,
                         input int irq_cyc, input int hold);
    int cyc, lat, n_setup, n_acc, irq_hit, hold_cnt, exit_cyc;
    int exp_lat, exp_acc, exp_setup;
    bit done, addr_bad, stable_bad, busy_bad, is_rw;
    logic exp_err, rsp_e0;
    logic [DW-1:0] exp_data, rsp_d0;

    is_rw = (op == CMD_WRITE) || (op == CMD_READ);
    exit_cyc = 0;
    if (is_rw) begin
      exp_setup = 1;
      if (nwait >= TMO) begin
        exp_acc = TMO; exp_lat = 2 + TMO; exp_err = 1'b1; exp_data = '0;
      end else begin
        exp_acc = nwait + 1; exp_lat = 3 + nwait; exp_err = 1'b0;
        exp_data = (op == CMD_READ) ? rdata : '0;
      end
      model_paddr = addr; model_pwdata = data; model_pwrite = (op == CMD_WRITE);
    end else if (op == CMD_WAIT_IRQ) begin
      exp_setup = 0; exp_acc = 0; exp_data = '0;
      if (model_irq || irq_cyc == 0) exit_cyc = 1;
      else if (irq_cyc >= 1 && irq_cyc <= TMO) exit_cyc = irq_cyc;
      else exit_cyc = TMO;
      exp_err = !(model_irq || (irq_cyc >= 0 && irq_cyc <= TMO));
      exp_lat = exit_cyc + 1;
    end else begin
      exp_setup = 0; exp_acc = 0; exp_data = '0; exp_err = 1'b1; exp_lat = 1;
    end

    chk({tag, ":cmd_ready"}, 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    interupt = (irq_cyc == 0);
    irq_hit = (irq_cyc == 0) ? 0 : -1;
    pready = 1'b0; rsp_ready = 1'b0;
    cyc = 0; lat = -1; n_setup = 0; n_acc = 0; hold_cnt = 0;
    done = 0; addr_bad = 0; stable_bad = 0; busy_bad = 0;
    rsp_d0 = '0; rsp_e0 = 1'b0;

    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      cmd_addr = AW'($urandom());
      cmd_data = rand_data();
      if (psel && !penable) n_setup++;
      if (psel && penable) n_acc++;
      if (psel && (paddr !== model_paddr || pwdata !== model_pwdata || pwrite !== model_pwrite))
        addr_bad = 1;
      interupt = (cyc == irq_cyc);
      if (cyc == irq_cyc) irq_hit = cyc;
      pready = psel && penable && (n_acc > nwait);
      prdata = pready ? rdata : rand_data();
      if (rsp_valid) begin
        if (lat < 0) begin
          lat = cyc; rsp_d0 = rsp_data; rsp_e0 = rsp_err;
          if (psel || penable) stable_bad = 1;
        end else if (rsp_data !== rsp_d0 || rsp_err !== rsp_e0) begin
          stable_bad = 1;
        end
        if (cmd_ready || !busy) stable_bad = 1;
        if (hold_cnt >= hold) rsp_ready = 1'b1;
        hold_cnt++;
      end else if (lat >= 0) begin
        done = 1;
      end else if (!busy) begin
        busy_bad = 1;
      end
    end
    interupt = 1'b0; pready = 1'b0; rsp_ready = 1'b0;

    chk({tag, ":completed"}, 128'(done), 128'(1));
    chk({tag, ":latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, ":total_cycles"}, 128'(cyc), 128'(exp_lat + hold + 1));
    chk({tag, ":rsp_data"}, 128'(rsp_d0), 128'(exp_data));
    chk({tag, ":rsp_err"}, 128'(rsp_e0), 128'(exp_err));
    chk({tag, ":setup_cycles"}, 128'(n_setup), 128'(exp_setup));
    chk({tag, ":access_cycles"}, 128'(n_acc), 128'(exp_acc));
    chk({tag, ":bus_stable"}, 128'(addr_bad), 128'(0));
    chk({tag, ":rsp_stable"}, 128'(stable_bad), 128'(0));
    chk({tag, ":busy_during"}, 128'(busy_bad), 128'(0));
    chk({tag, ":idle_after"}, 128'({busy, psel, penable, cmd_ready}), 128'(4'b0001));
    chk({tag, ":paddr_hold"}, 128'(paddr), 128'(model_paddr));
    chk({tag, ":pwdata_hold"}, 128'(pwdata), 128'(model_pwdata));

    if (op == CMD_WAIT_IRQ && !exp_err) model_irq = (irq_hit >= exit_cyc);
    else model_irq = model_irq | (irq_hit >= 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; interupt = 1'b0;
    model_irq = 1'b0; model_paddr = '0; model_pwdata = '0; model_pwrite = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset:cmd_ready", 128'(cmd_ready), 128'(0));
    chk("reset:ctrl", 128'({psel, penable, pwrite, rsp_valid, rsp_err, busy}), 128'(0));
    chk("reset:paddr", 128'(paddr), 128'(0));
    chk("reset:pwdata", 128'(pwdata), 128'(0));
    chk("reset:rsp_data", 128'(rsp_data), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset:cmd_ready", 128'(cmd_ready), 128'(1));

    run_cmd("wr_cent3", CMD_WRITE, AW'(cent_3), DW'(3), 0, rand_data(), -1, 0);
    run_cmd("rd_ramdata", CMD_READ, AW'(ram_data), rand_data(), 3, DW'(18), -1, 0);
    run_cmd("wr_stuck", CMD_WRITE, AW'(cent_1), rand_data(), TMO, rand_data(), -1, 0);
    run_cmd("wr_after_tmo", CMD_WRITE, AW'(ram_addr), rand_data(), 1, rand_data(), -1, 0);
    run_cmd("wr_irq", CMD_WRITE, AW'(go), rand_data(), 0, rand_data(), 2, 0);
    run_cmd("wait_irq_seen", CMD_WAIT_IRQ, '0, '0, 0, rand_data(), -1, 0);
    run_cmd("wait_irq_tmo", CMD_WAIT_IRQ, '0, '0, 0, rand_data(), -1, 0);
    run_cmd("illegal_op", 2'd3, AW'(cent_8), rand_data(), 0, rand_data(), -1, 0);
    run_cmd("rd_hold5", CMD_READ, AW'(last_ram_addr), rand_data(), 0, rand_data(), -1, 5);
    run_cmd("wait_irq_live", CMD_WAIT_IRQ, '0, '0, 0, rand_data(), 5, 0);
    run_cmd("wait_irq_sticky", CMD_WAIT_IRQ, '0, '0, 0, rand_data(), -1, 0);

    // Reset while the slave holds the transfer in ACCESS.
    cmd_valid = 1'b1; cmd_op = CMD_WRITE; cmd_addr = AW'(first_ram_addr); cmd_data = rand_data();
    pready = 1'b0; rsp_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid:in_access", 128'({psel, penable}), 128'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid:bus", 128'({psel, penable, busy, rsp_valid}), 128'(0));
    chk("rst_mid:paddr", 128'(paddr), 128'(0));
    chk("rst_mid:cmd_ready", 128'(cmd_ready), 128'(0));
    rst = 1'b0;
    model_irq = 1'b0; model_paddr = '0; model_pwdata = '0; model_pwrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid:no_rsp", 128'({rsp_valid, busy, cmd_ready}), 128'(3'b001));
    end
    rsp_ready = 1'b0;

    for (int i = 0; i < 30; i++) begin
      int r, nw, ic;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r <= 3) ? 2'(CMD_WRITE) : (r <= 6) ? 2'(CMD_READ) : (r <= 8) ? 2'(CMD_WAIT_IRQ) : 2'd3;
      nw = ($urandom_range(0, 9) == 0) ? TMO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
      ic = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_cmd("random", op, AW'($urandom()), rand_data(), nw, rand_data(), ic,
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
